conv_stream: RTL and testbench
==============================

CONV_STREAM -- requirements
Module: conv_stream

Parameters
REQ-001 SHALL have parameter K, default 3: kernel side; odd, 3..7.
REQ-002 SHALL have parameter WIDTH_BIT, default 8: pixel, kernel-coefficient and output width.
REQ-003 SHALL have parameter IMG_W, default 32: image columns, at least K.
REQ-004 SHALL have parameter IMG_H, default 32: image rows, at least K.
REQ-005 SHALL have parameter SHIFT, default 0: arithmetic right shift applied to the accumulator before clamping.

Interface
REQ-006 SHALL have port clock, input, 1: sole clock; all state changes on its rising edge.
REQ-007 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-008 SHALL have port start, input, 1: single-cycle pulse that begins a frame; honoured in IDLE only.
REQ-009 SHALL have port kernel_we, input, 1: coefficient write strobe.
REQ-010 SHALL have port kernel_addr, input, clog2(K*K): coefficient index, row*K+col.
REQ-011 SHALL have port kernel_data, input, WIDTH_BIT: signed coefficient.
REQ-012 SHALL have port pix_valid, input, 1: pixel offered.
REQ-013 SHALL have port pix_ready, output, 1: pixel accepted when pix_valid and pix_ready are both high.
REQ-014 SHALL have port pix_data, input, WIDTH_BIT: unsigned pixel, raster order.
REQ-015 SHALL have port out_valid, output, 1: result offered.
REQ-016 SHALL have port out_ready, input, 1: result consumed when out_valid and out_ready are both high.
REQ-017 SHALL have port out_data, output, WIDTH_BIT: unsigned clamped result.
REQ-018 SHALL have port out_last, output, 1: marks the final result of the frame.
REQ-019 SHALL have port done, output, 1: single-cycle pulse when the frame completes.
REQ-020 SHALL have port busy, output, 1: high in RUN and DRAIN.

Function
REQ-021 SHALL implement FSM IDLE -> RUN on start; RUN -> DRAIN once IMG_W*IMG_H pixels are accepted; DRAIN -> IDLE when the result carrying out_last is accepted, with done pulsing in that cycle.
REQ-022 SHALL write kernel_data to coefficient kernel_addr on kernel_we only in IDLE; writes in other states are ignored, as are writes with kernel_addr >= K*K.
REQ-023 SHALL hold pix_ready = (state==RUN) AND en, where en = !out_valid OR out_ready.
REQ-024 SHALL hold K-1 line buffers of IMG_W pixels and a KxK window register; these shift only on an accepted pixel.
REQ-025 SHALL track column and row counters of the accepted pixel; the column wraps IMG_W-1 -> 0 and increments the row.
REQ-026 SHALL mark a window valid when the accepted pixel has row >= K-1 and col >= K-1 (valid-mode convolution with no padding), giving (IMG_W-K+1)*(IMG_H-K+1) results per frame.
REQ-027 SHALL compute sum over r,c of window[r][c]*kernel[r*K+c], where r=0 is the oldest row and c=0 the oldest column (correlation, no flip).
REQ-028 SHALL treat pixels as unsigned and coefficients as signed; the accumulator SHALL be signed with width 2*WIDTH_BIT+clog2(K*K)+1 and SHALL NOT overflow.
REQ-029 SHALL arithmetic-shift the accumulator right by SHIFT, then clamp: below 0 -> 0; above 2^WIDTH_BIT-1 -> 2^WIDTH_BIT-1; otherwise the value.
REQ-030 SHALL use a two-stage pipeline: stage 1 registers the accumulator and window-valid flag; stage 2 registers the clamp result into out_data/out_valid. Both stages advance only when en is high.
REQ-031 SHALL present, with no stall, the result for the pixel accepted in cycle t with out_valid high in cycle t+2.
REQ-032 SHALL hold out_data and out_last stable while out_valid is high and out_ready is low.
REQ-033 SHALL assert out_last with the result whose window ends at row IMG_H-1, col IMG_W-1.
REQ-034 SHALL ignore start outside IDLE; pix_valid outside RUN causes no acceptance.

Reset
REQ-035 SHALL, on reset, force: state IDLE; counters 0; all coefficients 0; stage-1 valid 0; out_valid, out_last, done, busy and pix_ready 0; out_data 0.
REQ-036 SHALL abort any frame in progress on reset, with no further results; line-buffer contents need no reset.

Verification (K=3, IMG_W=4, IMG_H=4, WIDTH_BIT=8)
REQ-037 SHALL cover: all coefficients 1, SHIFT=0, pixels 0..15, out_ready held high -> outputs 45, 54, 81, 90; out_last on 90; done one cycle after its acceptance.
REQ-038 SHALL cover: all coefficients 1, all pixels 255 -> four outputs of 255 (clamp high); centre coefficient -1, others 0 -> four outputs of 0 (clamp low).
REQ-039 SHALL cover: SHIFT=3, all coefficients 1, pixels 0..15 -> outputs 5, 6, 10, 11.
REQ-040 SHALL cover: out_ready low for 5 cycles while out_valid is high -> out_data frozen, pix_ready low, no result lost or duplicated, and the same sequence as REQ-037.
REQ-041 SHALL cover: kernel_we pulsed in RUN with value 7 -> ignored, results unchanged; reset asserted after 9 pixels -> next cycle all outputs at reset values, and a new start frame produces correct results.

Source files
------------

// File: rtl/conv_stream.sv
// conv_stream: streaming KxK valid-mode 2-D correlation over a raster-order image.
// Unsigned pixels and signed coefficients; the result is shifted right by SHIFT and clamped to WIDTH_BIT bits.
module conv_stream #(
   parameter int K         = 3,
   parameter int WIDTH_BIT = 8,
   parameter int IMG_W     = 32,
   parameter int IMG_H     = 32,
   parameter int SHIFT     = 0
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   start,
   input  logic                   kernel_we,
   input  logic [$clog2(K*K)-1:0] kernel_addr,
   input  logic [WIDTH_BIT-1:0]   kernel_data,
   input  logic                   pix_valid,
   output logic                   pix_ready,
   input  logic [WIDTH_BIT-1:0]   pix_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [WIDTH_BIT-1:0]   out_data,
   output logic                   out_last,
   output logic                   done,
   output logic                   busy
);

   localparam int NK = K * K;
   localparam int AB = $clog2(NK);
   localparam int AW = 2 * WIDTH_BIT + AB + 1;
   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam int KB = $clog2(K);
   localparam int LB = $clog2(K - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN
   } state_t;

   state_t                      state_q, state_d;
   logic [CW-1:0]               col_q, col_d;
   logic [RW-1:0]               row_q, row_d;
   logic signed [WIDTH_BIT-1:0] coef_q [NK];
   logic signed [WIDTH_BIT-1:0] coef_d [NK];
   logic [WIDTH_BIT-1:0]        lb_q [K-1][IMG_W];
   logic [WIDTH_BIT-1:0]        lb_d [K-1][IMG_W];
   logic [WIDTH_BIT-1:0]        win_q [K][K];
   logic [WIDTH_BIT-1:0]        win_d [K][K];

   logic                        s1_valid_q, s1_valid_d;
   logic                        s1_last_q, s1_last_d;
   logic signed [AW-1:0]        s1_acc_q, s1_acc_d;
   logic                        out_valid_q, out_valid_d;
   logic                        out_last_q, out_last_d;
   logic [WIDTH_BIT-1:0]        out_data_q, out_data_d;
   logic                        done_q, done_d;
   logic                        busy_q, busy_d;

   logic                        en;
   logic                        accept;
   logic                        at_last_pix;
   logic                        win_ok;
   logic signed [AW-1:0]        acc;
   logic signed [AW-1:0]        shifted;
   logic [WIDTH_BIT-1:0]        clamped;

   // Frame control, pixel position and coefficient store
   always_comb begin
      en          = !out_valid_q || out_ready;
      pix_ready   = (state_q == S_RUN) && en;
      accept      = pix_valid && pix_ready;
      at_last_pix = (col_q == CW'(IMG_W - 1)) && (row_q == RW'(IMG_H - 1));
      win_ok      = (col_q >= CW'(K - 1)) && (row_q >= RW'(K - 1));

      state_d = state_q;
      col_d   = col_q;
      row_d   = row_q;
      coef_d  = coef_q;
      done_d  = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (kernel_we && (kernel_addr < AB'(NK))) begin
               coef_d[kernel_addr] = kernel_data;
            end
            if (start) begin
               state_d = S_RUN;
               col_d   = '0;
               row_d   = '0;
            end
         end
         S_RUN: begin
            if (accept) begin
               if (at_last_pix) begin
                  state_d = S_DRAIN;
                  col_d   = '0;
                  row_d   = '0;
               end else if (col_q == CW'(IMG_W - 1)) begin
                  col_d = '0;
                  row_d = row_q + 1'b1;
               end else begin
                  col_d = col_q + 1'b1;
               end
            end
         end
         S_DRAIN: begin
            if (out_valid_q && out_ready && out_last_q) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d != S_IDLE);
   end

   // Window and line buffers; the window is summed in its post-shift form so the
   // accepted pixel's result reaches stage 1 on its own acceptance edge.
   always_comb begin
      win_d = win_q;
      lb_d  = lb_q;
      if (accept) begin
         for (int unsigned r = 0; r < K; r++) begin
            for (int unsigned c = 0; c < K - 1; c++) begin
               win_d[KB'(r)][KB'(c)] = win_q[KB'(r)][KB'(c + 1)];
            end
         end
         win_d[KB'(K - 1)][KB'(K - 1)] = pix_data;
         for (int unsigned i = 0; i < K - 1; i++) begin
            win_d[KB'(K - 2 - i)][KB'(K - 1)] = lb_q[LB'(i)][col_q];
         end
         lb_d[0][col_q] = pix_data;
         for (int unsigned i = 1; i < K - 1; i++) begin
            lb_d[LB'(i)][col_q] = lb_q[LB'(i - 1)][col_q];
         end
      end

      acc = '0;
      for (int unsigned r = 0; r < K; r++) begin
         for (int unsigned c = 0; c < K; c++) begin
            acc = acc + AW'(signed'({1'b0, win_d[KB'(r)][KB'(c)]})) * AW'(coef_q[AB'(r * K + c)]);
         end
      end
   end

   // Shift and clamp of the stage-1 accumulator, then the two-stage pipeline
   always_comb begin
      shifted = s1_acc_q >>> SHIFT;
      if (shifted[AW-1]) begin
         clamped = '0;
      end else if (|shifted[AW-2:WIDTH_BIT]) begin
         clamped = '1;
      end else begin
         clamped = shifted[WIDTH_BIT-1:0];
      end

      s1_valid_d  = s1_valid_q;
      s1_last_d   = s1_last_q;
      s1_acc_d    = s1_acc_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      out_data_d  = out_data_q;
      if (en) begin
         s1_valid_d  = accept && win_ok;
         s1_last_d   = accept && at_last_pix;
         s1_acc_d    = acc;
         out_valid_d = s1_valid_q;
         out_last_d  = s1_valid_q && s1_last_q;
         if (s1_valid_q) begin
            out_data_d = clamped;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= S_IDLE;
         col_q       <= '0;
         row_q       <= '0;
         coef_q      <= '{default: '0};
         s1_valid_q  <= 1'b0;
         s1_last_q   <= 1'b0;
         s1_acc_q    <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_data_q  <= '0;
         done_q      <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         col_q       <= col_d;
         row_q       <= row_d;
         coef_q      <= coef_d;
         s1_valid_q  <= s1_valid_d;
         s1_last_q   <= s1_last_d;
         s1_acc_q    <= s1_acc_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         out_data_q  <= out_data_d;
         done_q      <= done_d;
         busy_q      <= busy_d;
      end
   end

   // Pixel storage carries no reset; stale contents never reach a valid window
   always_ff @(posedge clock) begin
      win_q <= win_d;
      lb_q  <= lb_d;
   end

   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign out_data  = out_data_q;
   assign done      = done_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_conv_stream.sv
// Scoreboard bench for conv_stream: two instances (SHIFT 0 and 3) share stimulus;
// expected results come from a direct window-sum model of each frame.
module tb_conv_stream;

   localparam int K    = 3;
   localparam int W    = 8;
   localparam int IW   = 4;
   localparam int IH   = 4;
   localparam int NPIX = IW * IH;
   localparam int NK   = K * K;

   logic       clock       = 1'b0;
   logic       reset       = 1'b1;
   logic       start       = 1'b0;
   logic       kernel_we   = 1'b0;
   logic [3:0] kernel_addr = '0;
   logic [7:0] kernel_data = '0;
   logic       pix_valid   = 1'b0;
   logic [7:0] pix_data    = '0;
   logic       out_ready   = 1'b1;

   logic [1:0] pix_ready, out_valid, out_last, done, busy;
   logic [7:0] out_data [2];

   conv_stream #(.K(K), .WIDTH_BIT(W), .IMG_W(IW), .IMG_H(IH), .SHIFT(0)) dut0 (
      .clock(clock), .reset(reset), .start(start), .kernel_we(kernel_we),
      .kernel_addr(kernel_addr), .kernel_data(kernel_data), .pix_valid(pix_valid),
      .pix_ready(pix_ready[0]), .pix_data(pix_data), .out_valid(out_valid[0]),
      .out_ready(out_ready), .out_data(out_data[0]), .out_last(out_last[0]),
      .done(done[0]), .busy(busy[0])
   );

   conv_stream #(.K(K), .WIDTH_BIT(W), .IMG_W(IW), .IMG_H(IH), .SHIFT(3)) dut3 (
      .clock(clock), .reset(reset), .start(start), .kernel_we(kernel_we),
      .kernel_addr(kernel_addr), .kernel_data(kernel_data), .pix_valid(pix_valid),
      .pix_ready(pix_ready[1]), .pix_data(pix_data), .out_valid(out_valid[1]),
      .out_ready(out_ready), .out_data(out_data[1]), .out_last(out_last[1]),
      .done(done[1]), .busy(busy[1])
   );

   always #5 clock = ~clock;

   int         n_cmp = 0;
   int         n_bad = 0;
   int         ref_k [NK];
   int         img [NPIX];
   logic [8:0] exp_q0 [$];
   logic [8:0] exp_q1 [$];
   int         rdy_mode   = 0;
   int         stall_left = 0;
   bit         stall_done = 1'b0;
   bit         gaps       = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fatal_timeout(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: timed out waiting for the DUT", name);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   endtask

   function automatic int model_px(input int orow, input int ocol, input int sh);
      int s = 0;
      for (int r = 0; r < K; r++)
         for (int c = 0; c < K; c++)
            s += img[(orow + r) * IW + ocol + c] * ref_k[r * K + c];
      s = s >>> sh;
      if (s < 0) s = 0;
      if (s > 255) s = 255;
      return s;
   endfunction

   task automatic push_expected();
      for (int orow = 0; orow <= IH - K; orow++)
         for (int ocol = 0; ocol <= IW - K; ocol++) begin
            logic lst;
            lst = (orow == IH - K) && (ocol == IW - K);
            exp_q0.push_back({lst, 8'(model_px(orow, ocol, 0))});
            exp_q1.push_back({lst, 8'(model_px(orow, ocol, 3))});
         end
   endtask

   // Monitor: pops the scoreboard on every accepted result, checks stall hold and done
   logic [1:0] exp_done   = '0;
   logic [1:0] stalled    = '0;
   logic [7:0] held_data [2];
   logic [1:0] held_last;

   task automatic monitor_one(input int d);
      logic [8:0] e;
      if (exp_done[d]) check($sformatf("done_pulse[%0d]", d), int'(done[d]), 1);
      else if (done[d]) check($sformatf("done_spurious[%0d]", d), int'(done[d]), 0);
      exp_done[d] = 1'b0;
      if (stalled[d]) begin
         check($sformatf("hold_valid[%0d]", d), int'(out_valid[d]), 1);
         check($sformatf("hold_data[%0d]", d), int'(out_data[d]), int'(held_data[d]));
         check($sformatf("hold_last[%0d]", d), int'(out_last[d]), int'(held_last[d]));
      end
      if (out_valid[d] && !out_ready) begin
         check($sformatf("stall_pix_ready[%0d]", d), int'(pix_ready[d]), 0);
         stalled[d]   = 1'b1;
         held_data[d] = out_data[d];
         held_last[d] = out_last[d];
      end else begin
         stalled[d] = 1'b0;
      end
      if (out_valid[d] && out_ready) begin
         if ((d == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_out[%0d]: got data %0d, expected no result", d, out_data[d]);
         end else begin
            e = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            check($sformatf("out_data[%0d]", d), int'(out_data[d]), int'(e[7:0]));
            check($sformatf("out_last[%0d]", d), int'(out_last[d]), int'(e[8]));
            if (e[8]) exp_done[d] = 1'b1;
         end
      end
   endtask

   always @(negedge clock) begin
      if (reset) begin
         exp_done = '0;
         stalled  = '0;
      end else begin
         for (int d = 0; d < 2; d++) monitor_one(d);
      end
   end

   // out_ready driver: 0 = held high, 1 = random, 2 = one 5-cycle stall on the first result
   initial forever begin
      @(posedge clock);
      #1;
      case (rdy_mode)
         1: out_ready = ($urandom_range(0, 3) != 0);
         2: begin
            if (stall_left > 0) begin
               out_ready = 1'b0;
               stall_left--;
            end else if (!stall_done && out_valid[0]) begin
               out_ready  = 1'b0;
               stall_left = 4;
               stall_done = 1'b1;
            end else begin
               out_ready = 1'b1;
            end
         end
         default: out_ready = 1'b1;
      endcase
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check_reset(input string tag);
      for (int d = 0; d < 2; d++) begin
         check($sformatf("%s_out_valid[%0d]", tag, d), int'(out_valid[d]), 0);
         check($sformatf("%s_out_last[%0d]", tag, d), int'(out_last[d]), 0);
         check($sformatf("%s_out_data[%0d]", tag, d), int'(out_data[d]), 0);
         check($sformatf("%s_done[%0d]", tag, d), int'(done[d]), 0);
         check($sformatf("%s_busy[%0d]", tag, d), int'(busy[d]), 0);
         check($sformatf("%s_pix_ready[%0d]", tag, d), int'(pix_ready[d]), 0);
      end
   endtask

   task automatic write_k(input int addr, input int data);
      kernel_we   = 1'b1;
      kernel_addr = 4'(addr);
      kernel_data = 8'(data);
      tick();
      kernel_we = 1'b0;
      if (addr < NK) ref_k[addr] = int'($signed(8'(data)));
   endtask

   task automatic load_kernel_all(input int v);
      for (int a = 0; a < NK; a++) write_k(a, v);
   endtask

   task automatic load_kernel_random();
      for (int a = 0; a < NK; a++) write_k(a, int'($urandom_range(0, 255)));
   endtask

   task automatic run_frame(input int abort_after, input bit kwe_in_run);
      bit acc_now;
      int guard;
      if (abort_after == 0) push_expected();
      start = 1'b1;
      tick();
      start = 1'b0;
      check("busy_after_start", int'(busy[0]), 1);
      for (int i = 0; i < NPIX; i++) begin
         if (gaps) begin
            pix_valid = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
         end
         pix_valid = 1'b1;
         pix_data  = 8'(img[i]);
         if (kwe_in_run && i == 5) begin
            kernel_we   = 1'b1;
            kernel_addr = 4'd4;
            kernel_data = 8'd7;
            start       = 1'b1;
         end
         guard = 0;
         forever begin
            @(negedge clock);
            acc_now = pix_ready[0];
            tick();
            kernel_we = 1'b0;
            start     = 1'b0;
            if (acc_now) break;
            guard++;
            if (guard > 100) fatal_timeout("pixel_accept");
         end
         if (abort_after != 0 && i + 1 == abort_after) begin
            pix_valid = 1'b0;
            reset     = 1'b1;
            exp_q0.delete();
            exp_q1.delete();
            tick();
            reset = 1'b0;
            @(negedge clock);
            check_reset("abort");
            for (int a = 0; a < NK; a++) ref_k[a] = 0;
            tick();
            return;
         end
      end
      pix_valid = 1'b0;
      guard = 0;
      forever begin
         @(negedge clock);
         if (done[0]) break;
         guard++;
         if (guard > 200) fatal_timeout("frame_done");
      end
      tick();
      check("busy_after_done", int'(busy[0]), 0);
   endtask

   task automatic img_ramp();
      for (int i = 0; i < NPIX; i++) img[i] = i;
   endtask

   task automatic img_random();
      for (int i = 0; i < NPIX; i++) img[i] = int'($urandom_range(0, 255));
   endtask

   initial begin
      for (int a = 0; a < NK; a++) ref_k[a] = 0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      check_reset("por");
      tick();
      reset = 1'b0;
      tick();

      // ramp image with unit kernel; out-of-range writes must be ignored
      load_kernel_all(1);
      write_k(9, 50);
      write_k(15, 200);
      img_ramp();
      run_frame(0, 1'b0);

      // saturate high
      for (int i = 0; i < NPIX; i++) img[i] = 255;
      run_frame(0, 1'b0);

      // centre -1: saturate low
      load_kernel_all(0);
      write_k(4, 255);
      img_random();
      run_frame(0, 1'b0);

      // back-pressure on the ramp frame
      load_kernel_all(1);
      img_ramp();
      rdy_mode = 2;
      run_frame(0, 1'b0);
      rdy_mode = 0;

      // pixels offered in IDLE are not accepted
      pix_valid = 1'b1;
      tick();
      check("idle_pix_ready", int'(pix_ready[0]), 0);
      pix_valid = 1'b0;

      // coefficient write and start in RUN are ignored
      load_kernel_random();
      img_random();
      rdy_mode = 1;
      gaps     = 1'b1;
      run_frame(0, 1'b1);

      // abort after 9 pixels, then a fresh frame
      run_frame(9, 1'b0);
      load_kernel_random();
      img_random();
      run_frame(0, 1'b0);

      for (int f = 0; f < 4; f++) begin
         load_kernel_random();
         img_random();
         run_frame(0, 1'b0);
      end

      rdy_mode = 0;
      repeat (5) tick();
      check("scoreboard_left_0", exp_q0.size(), 0);
      check("scoreboard_left_3", exp_q1.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      fatal_timeout("global_watchdog");
   end

endmodule
